// File: rtl/bit_stream_scheduler.sv
// Arbitrates the single bitBuffer write port between the 44-bit frame marker generator and the captured
// serial data stream. Optional statistics outputs (drop_cnt, frame_cnt) exist only when BSS_STATS_EN is defined.
module bit_stream_scheduler #(
    parameter int BLOCK_BITS = 2816,
    parameter int FRAME_BITS = 10240,
    parameter int SKID_DEPTH = 4
) (
    input  logic        clk240,
    input  logic        rst,
    input  logic        frm_start,
    input  logic        bit_stb,
    input  logic        bit_val,
    input  logic        fifo_full,
    output logic        fifo_wrreq,
    output logic        fifo_data,
    output logic        busy,
    output logic        frame_done,
    output logic        skid_ovf
`ifdef BSS_STATS_EN
    ,
    output logic [15:0] drop_cnt,
    output logic [15:0] frame_cnt
`endif
);

    localparam int SKID_PW = $clog2(SKID_DEPTH);
    localparam logic [13:0] FRAME_LIM = 14'(FRAME_BITS);
    localparam logic [11:0] BLOCK_LIM = 12'(BLOCK_BITS);
    localparam logic [SKID_PW:0] SKID_FULL = (SKID_PW + 1)'(SKID_DEPTH);
    localparam logic [5:0] MARK_TOP = 6'd43;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MARKER = 2'd1,
        DATA   = 2'd2
    } stateT;

    // Marker k: sync word M and block word B, each inverted by one bit of k.
    function automatic logic [43:0] markerWord(input logic [1:0] k);
        logic [30:0] m;
        logic [12:0] b;
        m = 31'b1111100110100100001010111011000;
        b = 13'b1111100110101;
        return {(k[0] ? ~m : m), (k[1] ? ~b : b)};
    endfunction

    stateT               state;
    stateT               stateNext;
    logic [1:0]          mkIdx;
    logic [1:0]          mkIdxNext;
    logic [5:0]          mkPtr;
    logic [5:0]          mkPtrNext;
    logic [13:0]         bitsCnt;
    logic [13:0]         bitsCntNext;
    logic [11:0]         blkCnt;
    logic [11:0]         blkCntNext;
    logic [13:0]         bitsInc;
    logic [11:0]         blkInc;
    logic                wrNext;
    logic                dataNext;
    logic                doneNext;
    logic                ovfClr;
    logic [43:0]         curMarker;

    logic                skidMem [SKID_DEPTH];
    logic [SKID_PW-1:0]  skidRd;
    logic [SKID_PW-1:0]  skidWr;
    logic [SKID_PW:0]    skidCnt;
    logic                skidPushReq;
    logic                skidPop;
    logic                skidFlush;
    logic                skidPushOk;
    logic                skidDrop;
    logic                skidHead;

    assign curMarker  = markerWord(mkIdx);
    assign bitsInc    = bitsCnt + 14'd1;
    assign blkInc     = blkCnt + 12'd1;
    assign skidHead   = skidMem[skidRd];
    // A pop in the same cycle frees the slot the push needs, so only a full queue without a pop drops.
    assign skidPushOk = skidPushReq && ((skidCnt != SKID_FULL) || skidPop);
    assign skidDrop   = skidPushReq && !skidPushOk;

    // Next-state, write-source selection and counter updates.
    always_comb begin
        stateNext   = state;
        mkIdxNext   = mkIdx;
        mkPtrNext   = mkPtr;
        bitsCntNext = bitsCnt;
        blkCntNext  = blkCnt;
        wrNext      = 1'b0;
        dataNext    = fifo_data;
        doneNext    = 1'b0;
        ovfClr      = 1'b0;
        skidPushReq = 1'b0;
        skidPop     = 1'b0;
        skidFlush   = 1'b0;
        if (frm_start) begin
            stateNext   = MARKER;
            mkIdxNext   = 2'd0;
            mkPtrNext   = MARK_TOP;
            bitsCntNext = 14'd0;
            blkCntNext  = 12'd0;
            skidFlush   = 1'b1;
            ovfClr      = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    stateNext = IDLE;
                end
                MARKER: begin
                    skidPushReq = bit_stb;
                    if (!fifo_full) begin
                        wrNext   = 1'b1;
                        dataNext = curMarker[mkPtr];
                        if (mkPtr == 6'd0) begin
                            mkIdxNext = mkIdx + 2'd1;
                            stateNext = DATA;
                        end else begin
                            mkPtrNext = mkPtr - 6'd1;
                        end
                    end else begin
                        wrNext = 1'b0;
                    end
                end
                DATA: begin
                    if (fifo_full) begin
                        skidPushReq = bit_stb;
                    end else if (skidCnt != '0) begin
                        skidPop     = 1'b1;
                        skidPushReq = bit_stb;
                        wrNext      = 1'b1;
                        dataNext    = skidHead;
                    end else if (bit_stb) begin
                        wrNext   = 1'b1;
                        dataNext = bit_val;
                    end else begin
                        wrNext = 1'b0;
                    end
                    if (wrNext) begin
                        bitsCntNext = bitsInc;
                        blkCntNext  = blkInc;
                        if (bitsInc == FRAME_LIM) begin
                            stateNext = IDLE;
                            doneNext  = 1'b1;
                            skidFlush = 1'b1;
                        end else if (blkInc == BLOCK_LIM) begin
                            blkCntNext = 12'd0;
                            mkPtrNext  = MARK_TOP;
                            stateNext  = MARKER;
                        end else begin
                            stateNext = DATA;
                        end
                    end else begin
                        stateNext = DATA;
                    end
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end
    end

    // State, counters and registered FIFO write port.
    always_ff @(posedge clk240 or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mkIdx      <= 2'd0;
            mkPtr      <= 6'd0;
            bitsCnt    <= 14'd0;
            blkCnt     <= 12'd0;
            fifo_wrreq <= 1'b0;
            fifo_data  <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            skid_ovf   <= 1'b0;
        end else begin
            state      <= stateNext;
            mkIdx      <= mkIdxNext;
            mkPtr      <= mkPtrNext;
            bitsCnt    <= bitsCntNext;
            blkCnt     <= blkCntNext;
            fifo_wrreq <= wrNext;
            fifo_data  <= dataNext;
            busy       <= (stateNext != IDLE);
            frame_done <= doneNext;
            if (ovfClr) begin
                skid_ovf <= 1'b0;
            end else if (skidDrop) begin
                skid_ovf <= 1'b1;
            end else begin
                skid_ovf <= skid_ovf;
            end
        end
    end

    // Skid queue holding data bits that cannot be written on arrival.
    always_ff @(posedge clk240 or negedge rst) begin
        if (!rst) begin
            skidRd  <= '0;
            skidWr  <= '0;
            skidCnt <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                skidMem[i] <= 1'b0;
            end
        end else if (skidFlush) begin
            skidRd  <= '0;
            skidWr  <= '0;
            skidCnt <= '0;
        end else begin
            if (skidPushOk) begin
                skidMem[skidWr] <= bit_val;
                skidWr          <= skidWr + 1'b1;
            end
            if (skidPop) begin
                skidRd <= skidRd + 1'b1;
            end
            case ({skidPushOk, skidPop})
                2'b10:   skidCnt <= skidCnt + 1'b1;
                2'b01:   skidCnt <= skidCnt - 1'b1;
                default: skidCnt <= skidCnt;
            endcase
        end
    end

`ifdef BSS_STATS_EN
    // Saturating drop counter and wrapping frame counter.
    always_ff @(posedge clk240 or negedge rst) begin
        if (!rst) begin
            drop_cnt  <= 16'd0;
            frame_cnt <= 16'd0;
        end else begin
            if (skidDrop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end else begin
                drop_cnt <= drop_cnt;
            end
            if (doneNext) begin
                frame_cnt <= frame_cnt + 16'd1;
            end else begin
                frame_cnt <= frame_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bit_stream_scheduler.sv
// Scoreboard bench for bit_stream_scheduler: a frame-position reference model predicts every write,
// a separate monitor compares DUT writes and status outputs against it.
module tb_bit_stream_scheduler;

    localparam int MARK_LEN  = 44;
    localparam int BLOCK_LEN = 2816;
    localparam int PERIOD    = MARK_LEN + BLOCK_LEN;
    localparam int FRAME_WR  = 10240 + 4 * MARK_LEN;
    localparam int SKID_CAP  = 4;

    logic clk240;
    logic rst;
    logic frm_start;
    logic bit_stb;
    logic bit_val;
    logic fifo_full;
    logic fifo_wrreq;
    logic fifo_data;
    logic busy;
    logic frame_done;
    logic skid_ovf;
`ifdef BSS_STATS_EN
    logic [15:0] drop_cnt;
    logic [15:0] frame_cnt;
`endif

    bit_stream_scheduler dut (
        .clk240     (clk240),
        .rst        (rst),
        .frm_start  (frm_start),
        .bit_stb    (bit_stb),
        .bit_val    (bit_val),
        .fifo_full  (fifo_full),
        .fifo_wrreq (fifo_wrreq),
        .fifo_data  (fifo_data),
        .busy       (busy),
        .frame_done (frame_done),
        .skid_ovf   (skid_ovf)
`ifdef BSS_STATS_EN
        ,
        .drop_cnt   (drop_cnt),
        .frame_cnt  (frame_cnt)
`endif
    );

    initial clk240 = 1'b0;
    always #5 clk240 = ~clk240;

    typedef struct {
        int   c;
        logic b;
    } expT;

    expT  sbq[$];
    logic mq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   mPos = 0;
    bit   mActive = 1'b0;
    bit   expBusy = 1'b0;
    bit   expDone = 1'b0;
    bit   expOvf = 1'b0;
    int   mDrops = 0;
    int   mFrames = 0;
    int   wrCount = 0;
    int   doneCount = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Marker bit at frame write position pos, taken straight from the M/B pattern definition.
    function automatic logic markerBit(input int pos);
        logic [30:0] m;
        logic [12:0] b;
        logic [43:0] w;
        int k;
        m = 31'b1111100110100100001010111011000;
        b = 13'b1111100110101;
        k = pos / PERIOD;
        w = {((k % 2) == 1) ? ~m : m, (((k / 2) % 2) == 1) ? ~b : b};
        return w[43 - (pos % PERIOD)];
    endfunction

    task automatic pushBit(input logic v);
        if (mq.size() >= SKID_CAP) begin
            expOvf = 1'b1;
            if (mDrops < 65535) mDrops++;
        end else begin
            mq.push_back(v);
        end
    endtask

    // Reference model: a frame is a fixed write sequence of 10416 positions; marker positions are
    // known from arithmetic, data positions are filled from the pending-bit queue or the live strobe.
    task automatic modelStep();
        expT  e;
        logic wb;
        bit   doWrite;
        if (!rst) begin
            mActive = 1'b0; mPos = 0; mq.delete(); expOvf = 1'b0;
            expDone = 1'b0; expBusy = 1'b0; mDrops = 0; mFrames = 0;
            return;
        end
        cyc++;
        expDone = 1'b0;
        doWrite = 1'b0;
        wb = 1'b0;
        if (frm_start) begin
            mActive = 1'b1; mPos = 0; mq.delete(); expOvf = 1'b0;
        end else if (mActive) begin
            if ((mPos % PERIOD) < MARK_LEN) begin
                if (bit_stb) pushBit(bit_val);
                if (!fifo_full) begin
                    doWrite = 1'b1;
                    wb = markerBit(mPos);
                end
            end else if (fifo_full) begin
                if (bit_stb) pushBit(bit_val);
            end else if (mq.size() > 0) begin
                wb = mq.pop_front();
                doWrite = 1'b1;
                if (bit_stb) pushBit(bit_val);
            end else if (bit_stb) begin
                wb = bit_val;
                doWrite = 1'b1;
            end
            if (doWrite) begin
                e.c = cyc;
                e.b = wb;
                sbq.push_back(e);
                mPos++;
                if (mPos == FRAME_WR) begin
                    mActive = 1'b0;
                    expDone = 1'b1;
                    mq.delete();
                    mFrames++;
                end
            end
        end
        expBusy = mActive;
    endtask

    initial forever begin
        @(posedge clk240);
        modelStep();
    end

    // Monitor: compares every DUT write and the status outputs against the model.
    initial forever begin
        expT e;
        @(negedge clk240);
        if (rst) begin
            if (fifo_wrreq) begin
                wrCount++;
                if (sbq.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("write_cycle", cyc, e.c);
                    check("write_bit", {31'd0, fifo_data}, {31'd0, e.b});
                end
            end else if (sbq.size() > 0 && sbq[0].c <= cyc) begin
                e = sbq.pop_front();
                check("missing_write", 32'd0, 32'd1);
            end
            if (frame_done) doneCount++;
            check("busy", {31'd0, busy}, {31'd0, expBusy});
            check("frame_done", {31'd0, frame_done}, {31'd0, expDone});
            check("skid_ovf", {31'd0, skid_ovf}, {31'd0, expOvf});
`ifdef BSS_STATS_EN
            check("drop_cnt", {16'd0, drop_cnt}, mDrops);
            check("frame_cnt", {16'd0, frame_cnt}, mFrames & 32'hFFFF);
`endif
        end
    end

    task automatic drive(input bit fs, input bit stb, input bit full);
        frm_start = fs;
        bit_stb   = stb;
        bit_val   = 1'($urandom_range(0, 1));
        fifo_full = full;
        @(negedge clk240);
        #1;
    endtask

    initial begin
        int w0;
        int d0;
        int k;
        rst = 1'b0; frm_start = 1'b0; bit_stb = 1'b0; bit_val = 1'b0; fifo_full = 1'b0;
        repeat (3) @(negedge clk240);
        #1;
        check("rst_wrreq", {31'd0, fifo_wrreq}, 32'd0);
        check("rst_data", {31'd0, fifo_data}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        check("rst_ovf", {31'd0, skid_ovf}, 32'd0);
        rst = 1'b1;
        drive(0, 0, 0);

        // Strobes in IDLE are ignored.
        w0 = wrCount;
        for (int i = 0; i < 20; i++) drive(0, (i % 3) == 0, 0);
        check("idle_writes", wrCount - w0, 32'd0);

        // Plain marker 0 with no data.
        w0 = wrCount;
        drive(1, 0, 0);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 50; i++) drive(0, 0, 0);
        check("mark0_writes", wrCount - w0, 32'd44);

        // Four strobes during a marker fit the skid queue.
        drive(1, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 1, 0);
        for (int i = 0; i < 60; i++) drive(0, 0, 0);
        check("burst4_ovf", {31'd0, skid_ovf}, 32'd0);

        // Five strobes overflow it by one.
        w0 = wrCount;
        drive(1, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, 0);
        for (int i = 0; i < 60; i++) drive(0, 0, 0);
        check("burst5_ovf", {31'd0, skid_ovf}, 32'd1);
        check("burst5_writes", wrCount - w0, 32'd48);

        // Stall at marker bit 20 for 10 cycles.
        drive(1, 0, 0);
        k = 0;
        while (mPos < 20 && k < 100) begin drive(0, 0, 0); k++; end
        w0 = wrCount;
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 1);
            check("stall_wrreq", {31'd0, fifo_wrreq}, 32'd0);
        end
        check("stall_writes", wrCount - w0, 32'd0);
        for (int i = 0; i < 40; i++) drive(0, 0, 0);

        // Abort near data bit 3000.
        drive(1, 0, 0);
        k = 0;
        while (mPos < 3000 + 2 * MARK_LEN && k < 20000) begin drive(0, (k % 2) == 0, 0); k++; end
        check("abort_reached", {31'd0, mPos >= 3000 + 2 * MARK_LEN}, 32'd1);
        drive(1, 1, 0);
        check("abort_ovf", {31'd0, skid_ovf}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 60; i++) drive(0, 0, 0);

        // Full frame with random stalls.
        w0 = wrCount;
        d0 = doneCount;
        drive(1, 0, 0);
        k = 0;
        while (mActive && k < 60000) begin
            drive(0, (k % 3) == 0, $urandom_range(0, 15) == 0);
            k++;
        end
        drive(0, 0, 0);
        check("frame_writes", wrCount - w0, FRAME_WR);
        check("frame_done_count", doneCount - d0, 32'd1);

        // Strobes after frame_done are ignored.
        w0 = wrCount;
        for (int i = 0; i < 20; i++) drive(0, 1, 0);
        check("post_frame_writes", wrCount - w0, 32'd0);
        check("post_frame_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 5; i++) drive(0, 0, 0);
        check("scoreboard_empty", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_stream_scheduler.md
# bit_stream_scheduler

Sequences all writes into the 1-bit capture FIFO (bitBuffer) in the clk240 domain. It shares the FIFO write port between the marker generator and the serial data capture path, and inserts a 44-bit frame marker before every data block. It also queues data bits that arrive while a marker is being written, and enforces the 10240-bit frame length. It sits between the dFM/dCLK/dDAT edge detectors and bitBuffer.

## Interface
- BLOCK_BITS, 2816: data bits between markers
- FRAME_BITS, 10240: data bits per frame
- SKID_DEPTH, 4: data bits held while a marker is written (power of 2)
- clk240  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- frm_start  in  1  one-cycle pulse, rising edge of dFM (already synchronised)
- bit_stb  in  1  one-cycle pulse, falling edge of dCLK (already synchronised)
- bit_val  in  1  dDAT sampled at bit_stb
- fifo_full  in  1  bitBuffer full
- fifo_wrreq  out  1  registered FIFO write request
- fifo_data  out  1  registered FIFO write bit
- busy  out  1  high in MARKER or DATA state
- frame_done  out  1  one-cycle pulse when FRAME_BITS data bits have been written
- skid_ovf  out  1  sticky; set when a data bit is dropped; cleared by frm_start or reset

## Operation
- Marker patterns:
  - M = 31'b1111100110100100001010111011000
  - B = 13'b1111100110101
  - marker k = {k[0] ? ~M : M, k[1] ? ~B : B}
  - Markers are written MSB first (bit 43 down to bit 0).
- States: IDLE, MARKER, DATA.
- IDLE:
  - bit_stb is ignored.
  - frm_start → MARKER, with mk_idx=0, mk_ptr=43, bits_cnt=0, blk_cnt=0, skid flushed, skid_ovf cleared.
- MARKER:
  - Each cycle with fifo_full=0: write marker[mk_idx][mk_ptr], then decrement mk_ptr.
  - After bit 0 is written: mk_idx += 1 (2-bit wrap) and state → DATA.
  - bit_stb in MARKER pushes bit_val into the skid queue.
- DATA:
  - Write source priority: skid head first, then the direct bit_stb bit.
  - A bit_stb that arrives while the skid queue is non-empty, or while fifo_full=1, is pushed into the queue. Order is strictly preserved.
  - Each data write increments bits_cnt (14 bits) and blk_cnt (12 bits).
  - When the write makes bits_cnt == FRAME_BITS: state → IDLE, frame_done pulses, and the skid queue is flushed.
  - Otherwise, when the write makes blk_cnt == BLOCK_BITS: blk_cnt=0, mk_ptr=43, state → MARKER. Skid contents are kept.
  - With default parameters, markers 0, 1, 2, 3 precede the bit ranges 0, 2816, 5632 and 8448.
- Skid queue:
  - A push while the queue is full drops the bit and sets skid_ovf.
  - A push and a pop in the same cycle are both allowed, and the count is unchanged.
- frm_start in MARKER or DATA aborts the current frame and restarts exactly as from IDLE. Any write in that cycle is suppressed.
- fifo_full=1: no write is issued, and all counters and pointers hold.

## Timing
- Reset values: fifo_wrreq=0, fifo_data=1, busy=0, frame_done=0, skid_ovf=0. State is IDLE and all counters are 0.
- frm_start sampled at edge E0 → busy is high after E0. The first marker bit is on fifo_wrreq/fifo_data after E1.
- A 44-bit marker takes 44 consecutive write cycles when not stalled.
- Direct data path: bit_stb sampled at edge E → write visible after edge E (1-cycle latency).
- fifo_full is sampled at the same edge that registers the write. A write is never issued in a cycle where fifo_full=1 was sampled.
- frame_done is high during the cycle that follows the edge registering the last data write. It coincides with that write.
- The MARKER → DATA and DATA → MARKER transitions each take zero extra cycles (no idle gap between writes).

## Configuration
- BSS_STATS_EN:
  - Defined: adds outputs drop_cnt[15:0] (saturating count of dropped bits) and frame_cnt[15:0] (wrapping count of frame_done pulses), both reset to 0.
  - Undefined: these ports and the logic behind them do not exist.

## Test plan
- Reset, then frm_start, with no bit_stb → 44 consecutive writes equal to mark0 MSB first; state DATA; busy=1.
- Full frame: frm_start, then 10240 bit_stb pulses 20 cycles apart → 4 markers (idx 0..3) and 10240 data bits in order; frame_done once; 10416 writes total.
- bit_stb burst of 4 pulses during a marker → 4 bits written immediately after marker bit 0, in order; skid_ovf=0. A burst of 5 pulses → 4 bits written, skid_ovf=1 (+1 on drop_cnt with BSS_STATS_EN).
- fifo_full held high for 10 cycles at marker bit 20 → fifo_wrreq=0 for those cycles; resumes at bit 20 with no loss or duplication.
- frm_start at data bit 3000 → current frame aborted; mark0 restarts; counters reset; skid flushed.
- bit_stb in IDLE and after frame_done → no writes.
